gshare_bht: RTL and testbench

GSHARE_BHT -- requirements
Module: gshare_bht

---
 rtl/bp_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/gshare_bht.sv | 97 +++++++++
 tb/tb_gshare_bht.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-prediction table.
package bp_pkg;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  // Weakly-taken value of a counter: only the MSB set.
  function automatic int unsigned weak_taken_init(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational next-state of an up/down saturating counter.
module sat_counter #(
  parameter int SATUR_COUNT_W = 2
) (
  input  logic [SATUR_COUNT_W-1:0] count,
  input  logic                     taken,
  output logic [SATUR_COUNT_W-1:0] next_count
);

  always_comb begin
    // NOTE: default first so every path assigns next_count and no latch is inferred.
    next_count = count;
    if (taken) begin
      if (count != '1) next_count = count + 1'b1;
    end else begin
      if (count != '0) next_count = count - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_bht.sv
// Branch history table of saturating counters, indexed bimodally or by
// PC XOR global history, with a one-cycle registered prediction.
module gshare_bht
  import bp_pkg::*;
#(
  parameter int       SET_COUNT     = 64,
  parameter int       INDEX_WIDTH   = 6,
  parameter int       SATUR_COUNT_W = 2,
  parameter int       GHR_WIDTH     = 6,
  parameter bp_mode_e MODE          = BP_GSHARE
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_pred_valid,
  input  logic [INDEX_WIDTH-1:0] i_pred_pc_index,
  output logic                   o_pred_valid,
  output logic                   o_pred_taken,
  output logic [INDEX_WIDTH-1:0] o_pred_index,
  input  logic                   i_bht_update,
  input  logic [INDEX_WIDTH-1:0] i_update_index,
  input  logic                   i_branch_taken,
  output logic [GHR_WIDTH-1:0]   o_ghr
);

  localparam int MSB = SATUR_COUNT_W - 1;
  localparam logic [SATUR_COUNT_W-1:0] CNT_INIT =
    SATUR_COUNT_W'(weak_taken_init(SATUR_COUNT_W));

  logic [SATUR_COUNT_W-1:0] table_q [SET_COUNT];
  logic [GHR_WIDTH-1:0]     ghr_q;
  logic [INDEX_WIDTH-1:0]   ghr_ext;
  logic [INDEX_WIDTH-1:0]   hash_idx;
  logic [SATUR_COUNT_W-1:0] upd_cur;
  logic [SATUR_COUNT_W-1:0] upd_next;
  logic                     pred_taken_d;
  logic                     pred_valid_q;
  logic                     pred_taken_q;
  logic [INDEX_WIDTH-1:0]   pred_index_q;

  // Hash uses the history as it stands before any same-cycle shift.
  assign ghr_ext  = INDEX_WIDTH'(ghr_q);
  assign hash_idx = (MODE == BP_GSHARE) ? (i_pred_pc_index ^ ghr_ext) : i_pred_pc_index;

  assign upd_cur = table_q[i_update_index];

  sat_counter #(
    .SATUR_COUNT_W(SATUR_COUNT_W)
  ) u_sat (
    .count     (upd_cur),
    .taken     (i_branch_taken),
    .next_count(upd_next)
  );

  // Write-first: a colliding update is visible to the prediction in the same cycle.
  assign pred_taken_d = (i_bht_update && (i_update_index == hash_idx))
                      ? upd_next[MSB] : table_q[hash_idx][MSB];

  for (genvar g = 0; g < SET_COUNT; g++) begin : g_entry
    // NOTE: the table is plain flops, so every entry takes the async reset value.
    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        table_q[g] <= CNT_INIT;
      end else if (i_bht_update && (i_update_index == INDEX_WIDTH'(g))) begin
        table_q[g] <= upd_next;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_arst) begin
      ghr_q <= '0;
    end else if (i_bht_update) begin
      ghr_q <= GHR_WIDTH'({ghr_q, i_branch_taken});
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
    end else begin
      pred_valid_q <= i_pred_valid;
      if (i_pred_valid) begin
        pred_taken_q <= pred_taken_d;
        pred_index_q <= hash_idx;
      end
    end
  end

  assign o_pred_valid = pred_valid_q;
  assign o_pred_taken = pred_taken_q;
  assign o_pred_index = pred_index_q;
  assign o_ghr        = ghr_q;

endmodule

// File: tb/tb_gshare_bht.sv
// Randomised and directed checks of gshare_bht against a behavioural table model.
module tb_gshare_bht;
  import bp_pkg::*;

  localparam int N    = 64;
  localparam int CMAX = 3;
  localparam int WEAK = 2;

  logic       i_clk = 1'b0;
  logic       i_arst;
  logic       i_pred_valid;
  logic [5:0] i_pred_pc_index;
  logic       o_pred_valid;
  logic       o_pred_taken;
  logic [5:0] o_pred_index;
  logic       i_bht_update;
  logic [5:0] i_update_index;
  logic       i_branch_taken;
  logic [5:0] o_ghr;

  gshare_bht #(
    .SET_COUNT    (64),
    .INDEX_WIDTH  (6),
    .SATUR_COUNT_W(2),
    .GHR_WIDTH    (6),
    .MODE         (BP_GSHARE)
  ) dut (
    .i_clk          (i_clk),
    .i_arst         (i_arst),
    .i_pred_valid   (i_pred_valid),
    .i_pred_pc_index(i_pred_pc_index),
    .o_pred_valid   (o_pred_valid),
    .o_pred_taken   (o_pred_taken),
    .o_pred_index   (o_pred_index),
    .i_bht_update   (i_bht_update),
    .i_update_index (i_update_index),
    .i_branch_taken (i_branch_taken),
    .o_ghr          (o_ghr)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counters as integers, history as an integer mod 64.
  int m_tbl [N];
  int m_ghr;
  int exp_valid, exp_taken, exp_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_step(input int c, input bit t);
    if (t) return (c < CMAX) ? c + 1 : c;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_tbl[i] = WEAK;
    m_ghr     = 0;
    exp_valid = 0;
    exp_taken = 0;
    exp_idx   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(o_pred_valid), 32'(exp_valid));
    check({tag, ".taken"}, 32'(o_pred_taken), 32'(exp_taken));
    check({tag, ".index"}, 32'(o_pred_index), 32'(exp_idx));
    check({tag, ".ghr"},   32'(o_ghr),        32'(m_ghr));
  endtask

  // One clock of stimulus; inputs change at posedge+1, outputs checked at next posedge+1.
  task automatic drive(input bit pv, input int pc, input bit upd, input int uidx, input bit tk);
    int hash, new_c, c;
    i_pred_valid    = pv;
    i_pred_pc_index = 6'(pc);
    i_bht_update    = upd;
    i_update_index  = 6'(uidx);
    i_branch_taken  = tk;
    hash  = (pc ^ m_ghr) % N;
    new_c = sat_step(m_tbl[uidx], tk);
    exp_valid = pv;
    if (pv) begin
      c = (upd && uidx == hash) ? new_c : m_tbl[hash];
      exp_taken = (c >= WEAK) ? 1 : 0;
      exp_idx   = hash;
    end
    if (upd) begin
      m_tbl[uidx] = new_c;
      m_ghr = ((m_ghr << 1) | int'(tk)) % N;
    end
    @(posedge i_clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  // Predict so that the hashed index lands on idx.
  task automatic pred(input int idx);
    drive(1, idx ^ m_ghr, 0, 0, 0);
  endtask

  task automatic upd(input int idx, input bit tk);
    drive(0, 0, 1, idx, tk);
  endtask

  // Reset with live inputs; none of them may take effect.
  task automatic do_reset();
    i_pred_valid    = 1'b1;
    i_pred_pc_index = 6'($urandom_range(0, 63));
    i_bht_update    = 1'b1;
    i_update_index  = 6'($urandom_range(0, 63));
    i_branch_taken  = 1'($urandom_range(0, 1));
    i_arst = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    @(posedge i_clk);
    #1;
    check_outputs("rst_held");
    i_arst = 1'b0;
  endtask

  initial begin
    int pc, hash, ui;
    bit pv, up, tk;
    i_arst = 1'b1;
    i_pred_valid = 0; i_pred_pc_index = 0;
    i_bht_update = 0; i_update_index = 0; i_branch_taken = 0;
    @(posedge i_clk);
    #1;
    do_reset();

    // Cold predict of pc 5 with empty history.
    drive(1, 5, 0, 0, 0);
    check("cold.valid", 32'(o_pred_valid), 32'd1);
    check("cold.taken", 32'(o_pred_taken), 32'd1);
    check("cold.index", 32'(o_pred_index), 32'd5);
    idle();
    check("cold.hold_index", 32'(o_pred_index), 32'd5);

    // Walk entry 3 down to zero, then one step up.
    for (int k = 0; k < 4; k++) begin
      upd(3, 0);
      pred(3);
    end
    check("dec.taken", 32'(o_pred_taken), 32'd0);
    upd(3, 1);
    pred(3);
    check("dec_inc.taken", 32'(o_pred_taken), 32'd0);

    // Saturate entry 7 upward; no wrap.
    for (int k = 0; k < 5; k++) begin
      upd(7, 1);
      pred(7);
    end
    check("sat.taken", 32'(o_pred_taken), 32'd1);

    // History shift and gshare hash.
    do_reset();
    upd(20, 1);
    upd(21, 0);
    upd(22, 1);
    check("ghr.pattern", 32'(o_ghr), 32'b000101);
    drive(1, 6'b001100, 0, 0, 0);
    check("hash.index", 32'(o_pred_index), 32'b001001);

    // Same-cycle predict and update on entry 2: bypass, pre-shift hash.
    do_reset();
    upd(10, 1);
    drive(1, 2 ^ 1, 1, 2, 0);
    check("byp.taken", 32'(o_pred_taken), 32'd0);
    check("byp.index", 32'(o_pred_index), 32'd2);
    check("byp.ghr",   32'(o_ghr),        32'd2);

    // Train edge entries, then reset mid-stream.
    do_reset();
    upd(0, 0);  upd(0, 0);
    upd(63, 0); upd(63, 0);
    pred(0);
    check("edge0.trained", 32'(o_pred_taken), 32'd0);
    pred(63);
    check("edge63.trained", 32'(o_pred_taken), 32'd0);
    do_reset();
    pred(0);
    check("edge0.reset", 32'(o_pred_taken), 32'd1);
    pred(63);
    check("edge63.reset", 32'(o_pred_taken), 32'd1);
    check("edge.ghr", 32'(o_ghr), 32'd0);

    // Random traffic with frequent index collisions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        pv = 1'($urandom_range(0, 3) != 0);
        up = 1'($urandom_range(0, 2) != 0);
        tk = 1'($urandom_range(0, 1));
        pc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
        hash = (pc ^ m_ghr) % N;
        case ($urandom_range(0, 3))
          0:       ui = hash;
          1:       ui = int'($urandom_range(0, 63));
          default: ui = int'($urandom_range(0, 7));
        endcase
        drive(pv, pc, up, ui, tk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
